// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - single-deck blackjack card dealer with per-rank counters
//
// Purpose: keeps a 52-card deck as 13 rank counters (0..4 each). A draw
//   picks a start rank from the free-running seed and walks forward one rank
//   per cycle until it finds a non-empty rank, then delivers that card.
// Ports:
//   clk_50M      system clock, rising-edge active
//   i_Reset_n    asynchronous active-low reset (full deck, IDLE)
//   i_Seed       free-running count used as the random source
//   i_Draw       draw request, sampled level, accepted only in IDLE
//   i_Shuffle    restore a full deck, accepted only in IDLE, beats i_Draw
//   o_Card       drawn rank 1..13 (A,2..10,J,Q,K); 0 after reset
//   o_Value      blackjack points of o_Card (J/Q/K = 10, Ace = 1)
//   o_Valid      one-cycle pulse marking a new o_Card/o_Value
//   o_Busy       high while a draw is in progress
//   o_Empty      high when no cards remain
//   o_Remaining  cards left in the deck (0..52)

module card_dealer #(
  parameter int SEED_WIDTH = 12
) (
  input  logic                  clk_50M,
  input  logic                  i_Reset_n,
  input  logic [SEED_WIDTH-1:0] i_Seed,
  input  logic                  i_Draw,
  input  logic                  i_Shuffle,
  output logic [3:0]            o_Card,
  output logic [3:0]            o_Value,
  output logic                  o_Valid,
  output logic                  o_Busy,
  output logic                  o_Empty,
  output logic [5:0]            o_Remaining
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] count_q [13];
  logic [2:0] count_d [13];
  logic [5:0] rem_q, rem_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] card_q, card_d;
  logic [3:0] value_q, value_d;
  logic [3:0] seed_idx;

  // Only the low nibble of the seed picks the start rank.
  logic unused_seed;
  assign unused_seed = ^i_Seed[SEED_WIDTH-1:4];

  // Fold 13..15 back onto 0..2 so every seed maps to a rank index.
  assign seed_idx = (i_Seed[3:0] >= 4'd13) ? (i_Seed[3:0] - 4'd13) : i_Seed[3:0];

  always_ff @(posedge clk_50M or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= IDLE;
      for (int r = 0; r < 13; r++) count_q[r] <= 3'd4;
      rem_q   <= 6'd52;
      idx_q   <= 4'd0;
      card_q  <= 4'd0;
      value_q <= 4'd0;
    end else begin
      state_q <= state_d;
      for (int r = 0; r < 13; r++) count_q[r] <= count_d[r];
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      card_q  <= card_d;
      value_q <= value_d;
    end
  end

  always_comb begin
    state_d = state_q;
    for (int r = 0; r < 13; r++) count_d[r] = count_q[r];
    rem_d   = rem_q;
    idx_d   = idx_q;
    card_d  = card_q;
    value_d = value_q;
    case (state_q)
      IDLE: begin
        if (i_Shuffle) begin
          for (int r = 0; r < 13; r++) count_d[r] = 3'd4;
          rem_d = 6'd52;
        end else if (i_Draw && (rem_q != 6'd0)) begin
          idx_d   = seed_idx;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        // Entered only with cards left, so this walk always finds one.
        if (count_q[idx_q] != 3'd0) begin
          count_d[idx_q] = count_q[idx_q] - 3'd1;
          rem_d          = rem_q - 6'd1;
          card_d         = idx_q + 4'd1;
          value_d        = (idx_q >= 4'd10) ? 4'd10 : (idx_q + 4'd1);
          state_d        = DELIVER;
        end else begin
          idx_d = (idx_q == 4'd12) ? 4'd0 : (idx_q + 4'd1);
        end
      end
      DELIVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_Card      = card_q;
  assign o_Value     = value_q;
  assign o_Valid     = (state_q == DELIVER);
  assign o_Busy      = (state_q != IDLE);
  assign o_Remaining = rem_q;
  assign o_Empty     = (rem_q == 6'd0);

endmodule
